leaf_user_bridge: RTL and testbench

LEAF_USER_BRIDGE -- requirements
Module: leaf_user_bridge

---
 rtl/leaf_user_bridge.sv | 183 ++++++++++++++++++
 tb/tb_leaf_user_bridge.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_user_bridge.sv
// Leaf/user stream bridge: per-channel 2-entry skid buffers and a run-control FSM.
// Optional per-output-channel word counters are enabled by LEAF_USER_BRIDGE_WORDCNT_EN.

module leaf_user_bridge_skid #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] s_data,
   input  logic         s_valid,
   output logic         s_ready,
   output logic [W-1:0] m_data,
   output logic         m_valid,
   input  logic         m_ready,
   output logic         empty
);
   logic [1:0]   count;
   logic [1:0]   count_next;
   logic [W-1:0] d0;
   logic [W-1:0] d1;
   logic         rdy;
   logic         push;
   logic         pop;

   assign m_valid = (count != 2'd0);
   assign empty   = (count == 2'd0);
   assign m_data  = d0;
   assign s_ready = rdy;
   assign push    = s_valid & rdy;
   assign pop     = m_valid & m_ready;

   always_comb begin
      count_next = count;
      case ({push, pop})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Ready is registered from next occupancy, so it never depends on s_valid combinationally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 2'd0;
         rdy   <= 1'b0;
         d0    <= '0;
         d1    <= '0;
      end else begin
         count <= count_next;
         rdy   <= en & (count_next != 2'd2);
         case (count)
            2'd0: if (push) d0 <= s_data;
            2'd1: begin
               if (push && pop) d0 <= s_data;
               else if (push)   d1 <= s_data;
            end
            2'd2: if (pop) d0 <= d1;
            default: d0 <= d0;
         endcase
      end
   end
endmodule

module leaf_user_bridge #(
   parameter int PAYLOAD_BITS  = 32,
   parameter int NUM_IN_PORTS  = 3,
   parameter int NUM_OUT_PORTS = 2,
   parameter int CNT_BITS      = 16
) (
   input  logic                                  ap_clk,
   input  logic                                  ap_rst_n,
   input  logic                                  start,
   input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  in_tdata,
   input  logic [NUM_IN_PORTS-1:0]               in_tvalid,
   output logic [NUM_IN_PORTS-1:0]               in_tready,
   output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  usr_in_tdata,
   output logic [NUM_IN_PORTS-1:0]               usr_in_tvalid,
   input  logic [NUM_IN_PORTS-1:0]               usr_in_tready,
   input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] usr_out_tdata,
   input  logic [NUM_OUT_PORTS-1:0]              usr_out_tvalid,
   output logic [NUM_OUT_PORTS-1:0]              usr_out_tready,
   output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] out_tdata,
   output logic [NUM_OUT_PORTS-1:0]              out_tvalid,
   input  logic [NUM_OUT_PORTS-1:0]              out_tready,
   output logic                                  usr_ap_start,
   input  logic                                  usr_ap_done,
   output logic                                  busy,
   output logic                                  done,
   output logic [NUM_OUT_PORTS*CNT_BITS-1:0]     out_word_cnt
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

   state_t                   state;
   state_t                   state_next;
   logic [NUM_IN_PORTS-1:0]  in_empty;
   logic [NUM_OUT_PORTS-1:0] out_empty;
   logic                     all_empty;
   logic                     in_en;

   assign all_empty = (&in_empty) & (&out_empty);
   assign in_en     = (state_next == ST_RUN);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start)       state_next = ST_RUN;   else state_next = ST_IDLE;
         ST_RUN:   if (usr_ap_done) state_next = ST_DRAIN; else state_next = ST_RUN;
         ST_DRAIN: if (all_empty)   state_next = ST_DONE;  else state_next = ST_DRAIN;
         ST_DONE:  state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // Status outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         state        <= ST_IDLE;
         usr_ap_start <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
      end else begin
         state        <= state_next;
         usr_ap_start <= (state_next == ST_RUN);
         busy         <= (state_next == ST_RUN) || (state_next == ST_DRAIN);
         done         <= (state_next == ST_DONE);
      end
   end

   for (genvar k = 0; k < NUM_IN_PORTS; k++) begin : g_in
      leaf_user_bridge_skid #(.W(PAYLOAD_BITS)) u_skid (
         .clk     (ap_clk),
         .rst_n   (ap_rst_n),
         .en      (in_en),
         .s_data  (in_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .s_valid (in_tvalid[k]),
         .s_ready (in_tready[k]),
         .m_data  (usr_in_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .m_valid (usr_in_tvalid[k]),
         .m_ready (usr_in_tready[k]),
         .empty   (in_empty[k])
      );
   end

   for (genvar k = 0; k < NUM_OUT_PORTS; k++) begin : g_out
      leaf_user_bridge_skid #(.W(PAYLOAD_BITS)) u_skid (
         .clk     (ap_clk),
         .rst_n   (ap_rst_n),
         .en      (1'b1),
         .s_data  (usr_out_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .s_valid (usr_out_tvalid[k]),
         .s_ready (usr_out_tready[k]),
         .m_data  (out_tdata[k*PAYLOAD_BITS +: PAYLOAD_BITS]),
         .m_valid (out_tvalid[k]),
         .m_ready (out_tready[k]),
         .empty   (out_empty[k])
      );
   end

`ifdef LEAF_USER_BRIDGE_WORDCNT_EN
   logic [NUM_OUT_PORTS*CNT_BITS-1:0] cnt;
   logic                              cnt_clear;

   assign cnt_clear    = (state == ST_IDLE) && (state_next == ST_RUN);
   assign out_word_cnt = cnt;

   // Counters wrap naturally at 2^CNT_BITS; a new run clears them.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         cnt <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT_PORTS; k++) begin
            if (cnt_clear)
               cnt[k*CNT_BITS +: CNT_BITS] <= '0;
            else if (out_tvalid[k] && out_tready[k])
               cnt[k*CNT_BITS +: CNT_BITS] <= cnt[k*CNT_BITS +: CNT_BITS] + CNT_BITS'(1);
         end
      end
   end
`else
   assign out_word_cnt = '0;
`endif
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Randomized bench for leaf_user_bridge with a queue-based reference model.
module tb_leaf_user_bridge;
   localparam int PB = 32;
   localparam int NI = 3;
   localparam int NO = 2;
   localparam int CB = 16;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic [NI*PB-1:0] in_tdata;
   logic [NI-1:0]    in_tvalid, in_tready;
   logic [NI*PB-1:0] usr_in_tdata;
   logic [NI-1:0]    usr_in_tvalid, usr_in_tready;
   logic [NO*PB-1:0] usr_out_tdata;
   logic [NO-1:0]    usr_out_tvalid, usr_out_tready;
   logic [NO*PB-1:0] out_tdata;
   logic [NO-1:0]    out_tvalid, out_tready;
   logic usr_ap_start, usr_ap_done, busy, done;
   logic [NO*CB-1:0] out_word_cnt;

   always #5 clk = ~clk;

   leaf_user_bridge #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO), .CNT_BITS(CB)) dut (
      .ap_clk(clk), .ap_rst_n(rst_n), .start(start),
      .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
      .usr_in_tdata(usr_in_tdata), .usr_in_tvalid(usr_in_tvalid), .usr_in_tready(usr_in_tready),
      .usr_out_tdata(usr_out_tdata), .usr_out_tvalid(usr_out_tvalid), .usr_out_tready(usr_out_tready),
      .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
      .usr_ap_start(usr_ap_start), .usr_ap_done(usr_ap_done), .busy(busy), .done(done),
      .out_word_cnt(out_word_cnt)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model: 0 idle, 1 run, 2 drain, 3 done; each buffer is a queue of at most two words.
   int            mst;
   logic [PB-1:0] iq[NI][$];
   logic [PB-1:0] oq[NO][$];
   bit            irdy[NI];
   bit            ordy[NO];
   int unsigned   mcnt[NO];

   int unsigned in_seq[NI], out_seq[NO];
   int          in_left[NI], out_left[NO];
   int          p_iv, p_ur, p_uv, p_or;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mst = 0;
      for (int k = 0; k < NI; k++) begin iq[k].delete(); irdy[k] = 1'b0; end
      for (int k = 0; k < NO; k++) begin oq[k].delete(); ordy[k] = 1'b0; mcnt[k] = 0; end
   endtask

   task automatic model_step();
      bit empty;
      int ns;
      empty = 1'b1;
      for (int k = 0; k < NI; k++) if (iq[k].size() != 0) empty = 1'b0;
      for (int k = 0; k < NO; k++) if (oq[k].size() != 0) empty = 1'b0;
      case (mst)
         0:       ns = start ? 1 : 0;
         1:       ns = usr_ap_done ? 2 : 1;
         2:       ns = empty ? 3 : 2;
         default: ns = 0;
      endcase
      for (int k = 0; k < NI; k++) begin
         bit push, pop;
         push = in_tvalid[k] && irdy[k];
         pop  = (iq[k].size() > 0) && usr_in_tready[k];
         if (pop) void'(iq[k].pop_front());
         if (push) begin
            iq[k].push_back(in_tdata[k*PB +: PB]);
            in_seq[k]++;
            in_left[k]--;
         end
         irdy[k] = (ns == 1) && (iq[k].size() < 2);
      end
      for (int k = 0; k < NO; k++) begin
         bit push, pop;
         push = usr_out_tvalid[k] && ordy[k];
         pop  = (oq[k].size() > 0) && out_tready[k];
         if (pop) void'(oq[k].pop_front());
         if (push) begin
            oq[k].push_back(usr_out_tdata[k*PB +: PB]);
            out_seq[k]++;
            out_left[k]--;
         end
         if (mst == 0 && ns == 1) mcnt[k] = 0;
         else if (pop) mcnt[k] = (mcnt[k] + 1) % (1 << CB);
         ordy[k] = (oq[k].size() < 2);
      end
      mst = ns;
   endtask

   task automatic check_outputs();
      for (int k = 0; k < NI; k++) begin
         check_eq("in_tready", in_tready[k], irdy[k]);
         check_eq("usr_in_tvalid", usr_in_tvalid[k], iq[k].size() > 0);
         if (iq[k].size() > 0) check_eq("usr_in_tdata", usr_in_tdata[k*PB +: PB], iq[k][0]);
      end
      for (int k = 0; k < NO; k++) begin
         check_eq("usr_out_tready", usr_out_tready[k], ordy[k]);
         check_eq("out_tvalid", out_tvalid[k], oq[k].size() > 0);
         if (oq[k].size() > 0) check_eq("out_tdata", out_tdata[k*PB +: PB], oq[k][0]);
`ifdef LEAF_USER_BRIDGE_WORDCNT_EN
         check_eq("out_word_cnt", out_word_cnt[k*CB +: CB], mcnt[k]);
`else
         check_eq("out_word_cnt", out_word_cnt[k*CB +: CB], 0);
`endif
      end
      check_eq("status", {usr_ap_start, busy, done}, {mst == 1, (mst == 1) || (mst == 2), mst == 3});
   endtask

   task automatic drive();
      for (int k = 0; k < NI; k++) begin
         in_tvalid[k] = (in_left[k] > 0) && ($urandom % 100 < p_iv);
         in_tdata[k*PB +: PB] = (k << 24) | in_seq[k];
         usr_in_tready[k] = ($urandom % 100 < p_ur);
      end
      for (int k = 0; k < NO; k++) begin
         usr_out_tvalid[k] = (out_left[k] > 0) && ($urandom % 100 < p_uv);
         usr_out_tdata[k*PB +: PB] = 32'h8000_0000 | (k << 24) | out_seq[k];
         out_tready[k] = ($urandom % 100 < p_or);
      end
   endtask

   task automatic cycle();
      check_outputs();
      drive();
      @(posedge clk);
      if (!rst_n) model_reset(); else model_step();
      #1;
   endtask

   task automatic finish_run();
      bit seen;
      seen = 1'b0;
      p_iv = 0; p_uv = 0; p_ur = 100;
      usr_ap_done = 1'b1;
      cycle();
      usr_ap_done = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
         if (done) seen = 1'b1;
         cycle();
      end
      check_eq("done_pulse_seen", seen, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; usr_ap_done = 1'b0;
      p_iv = 0; p_ur = 0; p_uv = 0; p_or = 0;
      for (int k = 0; k < NI; k++) begin in_seq[k] = 1; in_left[k] = 0; end
      for (int k = 0; k < NO; k++) begin out_seq[k] = 0; out_left[k] = 0; end
      drive();
      repeat (2) @(posedge clk);
      model_reset();
      #1;
      repeat (2) cycle();
      rst_n = 1'b1;

      // Idle with all inputs valid: nothing may be accepted.
      for (int k = 0; k < NI; k++) in_left[k] = 10;
      p_iv = 100;
      repeat (10) cycle();
      check_eq("idle_in_tready", in_tready, 3'b000);
      check_eq("idle_busy", busy, 1'b0);

      // Start with a coincident usr_ap_done: must go to RUN only; 8 words on channel 1.
      for (int k = 0; k < NI; k++) in_left[k] = 0;
      in_left[1] = 8; p_iv = 100; p_ur = 100; p_or = 100;
      start = 1'b1; usr_ap_done = 1'b1;
      cycle();
      start = 1'b0; usr_ap_done = 1'b0;
      check_eq("start_wins_over_done", {usr_ap_start, busy}, 2'b11);
      repeat (14) cycle();
      finish_run();

      // Backpressure: 5 words offered on channel 0 with the user stalled.
      in_left[0] = 5; p_iv = 100; p_ur = 0;
      start = 1'b1; cycle(); start = 1'b0;
      repeat (8) cycle();
      check_eq("skid_full_ready", in_tready[0], 1'b0);
      check_eq("skid_full_valid", usr_in_tvalid[0], 1'b1);
      p_ur = 100;
      repeat (10) cycle();
      finish_run();

      // 300 words on output channel 1 with out_tready toggling randomly.
      out_left[1] = 300; p_uv = 100; p_or = 50;
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 3000 && out_left[1] > 0; i++) cycle();
      check_eq("out300_pushed", out_left[1], 0);
      finish_run();
`ifdef LEAF_USER_BRIDGE_WORDCNT_EN
      check_eq("cnt1_300", out_word_cnt[CB +: CB], 16'd300);
`else
      check_eq("cnt1_300", out_word_cnt[CB +: CB], 16'd0);
`endif

      // Random runs with ignored start pulses while busy.
      for (int r = 0; r < 6; r++) begin
         for (int k = 0; k < NI; k++) in_left[k] = $urandom_range(0, 20);
         for (int k = 0; k < NO; k++) out_left[k] = $urandom_range(0, 20);
         p_iv = $urandom_range(20, 100); p_ur = $urandom_range(20, 100);
         p_uv = $urandom_range(20, 100); p_or = $urandom_range(20, 100);
         start = 1'b1; cycle(); start = 1'b0;
         for (int i = 0; i < 60; i++) begin
            start = ($urandom % 10 == 0);
            cycle();
         end
         start = 1'b0;
         finish_run();
      end

      // Reset in the middle of RUN with traffic in flight.
      for (int k = 0; k < NI; k++) in_left[k] = 6;
      for (int k = 0; k < NO; k++) out_left[k] = 6;
      p_iv = 100; p_ur = 30; p_uv = 100; p_or = 30;
      start = 1'b1; cycle(); start = 1'b0;
      repeat (5) cycle();
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      check_eq("rst_run_in_valid", usr_in_tvalid, 3'b000);
      check_eq("rst_run_out_valid", out_tvalid, 2'b00);
      cycle();
      check_eq("post_rst_out_ready", usr_out_tready, 2'b11);
      check_eq("post_rst_in_ready", in_tready, 3'b000);

      // Reset in the middle of DRAIN with two words held: no done pulse, all valids drop.
      for (int k = 0; k < NI; k++) in_left[k] = 0;
      for (int k = 0; k < NO; k++) out_left[k] = 0;
      in_left[0] = 4; p_iv = 100; p_ur = 0; p_uv = 0; p_or = 100;
      start = 1'b1; cycle(); start = 1'b0;
      repeat (6) cycle();
      usr_ap_done = 1'b1; cycle(); usr_ap_done = 1'b0;
      repeat (2) cycle();
      check_eq("drain_busy", busy, 1'b1);
      check_eq("drain_held", usr_in_tvalid[0], 1'b1);
      rst_n = 1'b0; cycle(); rst_n = 1'b1;
      check_eq("rst_drain_valid", usr_in_tvalid, 3'b000);
      check_eq("rst_drain_status", {busy, done, usr_ap_start}, 3'b000);
      p_ur = 100;
      repeat (5) cycle();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
